adsr_env_ctrl: RTL



---
 rtl/adsr_env_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/adsr_env_ctrl.sv
// adsr_env_ctrl: gate-driven ADSR envelope sequencer producing a Q1.6 gain code.
// Define ADSR_ENV_LEGATO_EN to ignore note_on while a note is still held.
module adsr_env_ctrl #(
  parameter int STEP_LEN_W       = 16,
  parameter int DEFAULT_STEP_LEN = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_ready,
  input  logic                  note_on,
  input  logic                  note_off,
  input  logic [STEP_LEN_W-1:0] cfg_step_len,
  output logic [2:0]            env_state,
  output logic [3:0]            env_step,
  output logic [6:0]            gain,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ATK  = 3'd1;
  localparam logic [2:0] S_DEC  = 3'd2;
  localparam logic [2:0] S_SUS  = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;

  localparam logic [3:0] LAST_STEP = 4'd9;
  localparam logic [STEP_LEN_W-1:0] DEF_LEN =
    STEP_LEN_W'(DEFAULT_STEP_LEN);
  localparam logic [STEP_LEN_W-1:0] ONE =
    STEP_LEN_W'(1);

  logic [2:0]            state_q, state_d;
  logic [3:0]            step_q, step_d;
  logic [STEP_LEN_W-1:0] cnt_q, cnt_d;
  logic [STEP_LEN_W-1:0] len_q, len_d;
  logic [6:0]            gain_q, gain_d;
  logic                  done_q, done_d;

  logic legal;
  logic in_note;
  logic timed;
  logic on_acc;
  logic off_acc;
  logic step_end;

  function automatic logic [6:0] gain_lut(
    input logic [2:0] st,
    input logic [3:0] sp
  );
    logic [6:0] g;
    g = 7'd0;
    case (st)
      S_ATK: begin
        case (sp)
          4'd0:    g = 7'd6;
          4'd1:    g = 7'd13;
          4'd2:    g = 7'd19;
          4'd3:    g = 7'd26;
          4'd4:    g = 7'd32;
          4'd5:    g = 7'd38;
          4'd6:    g = 7'd45;
          4'd7:    g = 7'd51;
          4'd8:    g = 7'd58;
          default: g = 7'd64;
        endcase
      end
      S_DEC: begin
        case (sp)
          4'd0:    g = 7'd60;
          4'd1:    g = 7'd56;
          4'd2:    g = 7'd52;
          4'd3:    g = 7'd48;
          4'd4:    g = 7'd45;
          4'd5:    g = 7'd42;
          4'd6:    g = 7'd40;
          4'd7:    g = 7'd37;
          4'd8:    g = 7'd34;
          default: g = 7'd32;
        endcase
      end
      S_SUS: g = 7'd32;
      S_REL: begin
        case (sp)
          4'd0:    g = 7'd32;
          4'd1:    g = 7'd28;
          4'd2:    g = 7'd26;
          4'd3:    g = 7'd22;
          4'd4:    g = 7'd20;
          4'd5:    g = 7'd16;
          4'd6:    g = 7'd13;
          4'd7:    g = 7'd10;
          4'd8:    g = 7'd6;
          default: g = 7'd4;
        endcase
      end
      default: g = 7'd0;
    endcase
    return g;
  endfunction

  assign legal   = (state_q <= S_REL);
  assign in_note = (state_q == S_ATK) ||
                   (state_q == S_DEC) ||
                   (state_q == S_SUS);
  assign timed   = (state_q == S_ATK) ||
                   (state_q == S_DEC) ||
                   (state_q == S_REL);

`ifdef ADSR_ENV_LEGATO_EN
  assign on_acc = note_on && !in_note;
`else
  assign on_acc = note_on;
`endif

  assign off_acc  = note_off && in_note;
  assign step_end = (cnt_q == len_q - ONE);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = 1'b0;
    if (!legal) begin
      state_d = S_IDLE;
      step_d  = 4'd0;
      cnt_d   = '0;
    end else if (on_acc) begin
      state_d = S_ATK;
      step_d  = 4'd0;
      cnt_d   = '0;
      len_d   = (cfg_step_len == '0) ? DEF_LEN : cfg_step_len;
    end else if (off_acc) begin
      state_d = S_REL;
      step_d  = 4'd0;
      cnt_d   = '0;
    end else if (in_ready && timed) begin
      if (step_end) begin
        cnt_d = '0;
        if (step_q == LAST_STEP) begin
          step_d = 4'd0;
          case (state_q)
            S_ATK:   state_d = S_DEC;
            S_DEC:   state_d = S_SUS;
            default: begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          endcase
        end else begin
          step_d = step_q + 4'd1;
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
    // Gain follows next state so it never lags env_state/env_step.
    gain_d = gain_lut(state_d, step_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      step_q  <= 4'd0;
      cnt_q   <= '0;
      len_q   <= DEF_LEN;
      gain_q  <= 7'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      gain_q  <= gain_d;
      done_q  <= done_d;
    end
  end

  assign env_state = state_q;
  assign env_step  = step_q;
  assign gain      = gain_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule
